// File: rtl/l1_burst_arbiter_pkg.sv
// Shared types for the L1-to-L2 burst arbiter: pushed-request record, arbiter state
// and the conventional L1 port assignments.
package l1_burst_arbiter_pkg;

    // Widest field sizes any configuration may use. Narrower builds zero-extend into them.
    localparam int unsigned L2_ADDR_MAX_W = 64;
    localparam int unsigned L2_SIZE_MAX_W = 8;
    localparam int unsigned L2_SUB_MAX_W  = 8;

    typedef struct packed {
        logic [L2_ADDR_MAX_W-1:0] addr;
        logic                     rnw;
        logic                     is_amo;
        logic [L2_SIZE_MAX_W-1:0] size;
        logic [L2_SUB_MAX_W-1:0]  sub_id;
    } l2_req_t;

    typedef enum logic [0:0] {
        StArb,
        StWdata
    } arb_state_e;

    localparam int unsigned PORT_DCACHE   = 0;
    localparam int unsigned PORT_ICACHE   = 1;
    localparam int unsigned PORT_MMU_ITLB = 2;
    localparam int unsigned PORT_MMU_DTLB = 3;

endpackage

// File: rtl/l1_burst_arbiter_rr_priority_select.sv
// Rotating priority picker: the first set bit of req at or after ptr (wrapping) wins.
// With ptr tied to 0 it degenerates to lowest-index-first fixed priority.
module rr_priority_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        logic [31:0]      j;
        logic [IDX_W-1:0] j_idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j     = (32'(ptr) + k) % N;
            j_idx = IDX_W'(j);
            if (!gnt_valid && req[j_idx]) begin
                gnt_valid  = 1'b1;
                gnt[j_idx] = 1'b1;
                gnt_idx    = j_idx;
            end
        end
    end

endmodule

// File: rtl/l1_burst_arbiter.sv
// N-port L1-to-L2 request arbiter with locked write bursts and per-port read credits.
// Define L1_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module l1_burst_arbiter
    import l1_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SIZE_W       = 5,
    parameter int unsigned MAX_RD_BEATS = 16,
    localparam int unsigned SUB_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned BE_W        = DATA_W / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_valid,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS-1:0]                req_rnw,
    input  logic [NUM_PORTS-1:0]                req_is_amo,
    input  logic [NUM_PORTS-1:0][SIZE_W-1:0]    req_size,
    output logic [NUM_PORTS-1:0]                req_ack,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wr_data,
    input  logic [NUM_PORTS-1:0][BE_W-1:0]      wr_be,
    input  logic [NUM_PORTS-1:0]                wr_valid,
    output logic [NUM_PORTS-1:0]                wr_ack,
    input  logic                                l2_request_full,
    input  logic                                l2_data_full,
    output logic                                l2_request_push,
    output logic [ADDR_W-1:0]                   l2_addr,
    output logic                                l2_rnw,
    output logic                                l2_is_amo,
    output logic [SIZE_W-1:0]                   l2_size,
    output logic [SUB_W-1:0]                    l2_sub_id,
    output logic                                l2_wr_data_push,
    output logic [DATA_W-1:0]                   l2_wr_data,
    output logic [BE_W-1:0]                     l2_wr_data_be,
    input  logic                                l2_rd_data_valid,
    input  logic [DATA_W-1:0]                   l2_rd_data,
    input  logic [SUB_W-1:0]                    l2_rd_sub_id,
    output logic                                l2_rd_data_ack,
    output logic [DATA_W-1:0]                   resp_data,
    output logic [NUM_PORTS-1:0]                resp_valid
);

    localparam int unsigned CNT_W = $clog2(MAX_RD_BEATS + 1);

    arb_state_e                           state_q, state_d;
    logic       [SIZE_W-1:0]              beats_left_q, beats_left_d;
    logic       [SUB_W-1:0]               lock_port_q, lock_port_d;
    logic       [NUM_PORTS-1:0][CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic                 push_ready;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] sel_onehot;
    logic [SUB_W-1:0]     sel_idx;
    logic [SUB_W-1:0]     sel_ptr;
    logic                 sel_valid;
    logic                 grant;
    logic [NUM_PORTS-1:0] ret_hit;
    l2_req_t              l2_req;
    logic                 unused_l2_req;

    assign push_ready = ~(l2_request_full | l2_data_full);

    // Reads and AMOs must fit their beats within the remaining credit; writes need a beat ready.
    always_comb begin
        logic [31:0] need;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            need = 32'(rd_cnt_q[i]) + (req_is_amo[i] ? 32'd1 : 32'(req_size[i]) + 32'd1);
            eligible[i] = req_valid[i] &
                          ((req_rnw[i] | req_is_amo[i]) ? (need <= MAX_RD_BEATS) : wr_valid[i]);
        end
    end

    rr_priority_select #(
        .N     (NUM_PORTS),
        .IDX_W (SUB_W)
    ) u_select (
        .req       (eligible),
        .ptr       (sel_ptr),
        .gnt       (sel_onehot),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    assign grant = (state_q == StArb) & push_ready & sel_valid & ~rst;

`ifdef L1_ARB_ROUND_ROBIN_EN
    logic [SUB_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (32'(sel_idx) == NUM_PORTS - 1) ? '0 : sel_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign sel_ptr = rr_ptr_q;
`else
    assign sel_ptr = '0;
`endif

    always_comb begin
        state_d         = state_q;
        beats_left_d    = beats_left_q;
        lock_port_d     = lock_port_q;
        req_ack         = '0;
        wr_ack          = '0;
        l2_request_push = 1'b0;
        l2_wr_data_push = 1'b0;
        l2_req          = '0;
        l2_wr_data      = '0;
        l2_wr_data_be   = '0;
        unique case (state_q)
            StArb: begin
                if (grant) begin
                    l2_request_push = 1'b1;
                    req_ack         = sel_onehot;
                    l2_req.addr     = L2_ADDR_MAX_W'(req_addr[sel_idx]);
                    l2_req.rnw      = req_rnw[sel_idx];
                    l2_req.is_amo   = req_is_amo[sel_idx];
                    l2_req.size     = L2_SIZE_MAX_W'(req_size[sel_idx]);
                    l2_req.sub_id   = L2_SUB_MAX_W'(sel_idx);
                    if (!req_rnw[sel_idx] && !req_is_amo[sel_idx]) begin
                        // First write beat travels with the address.
                        wr_ack          = sel_onehot;
                        l2_wr_data_push = 1'b1;
                        l2_wr_data      = wr_data[sel_idx];
                        l2_wr_data_be   = wr_be[sel_idx];
                        if (req_size[sel_idx] != '0) begin
                            state_d      = StWdata;
                            beats_left_d = req_size[sel_idx];
                            lock_port_d  = sel_idx;
                        end
                    end
                end
            end
            StWdata: begin
                if (!rst && wr_valid[lock_port_q] && !l2_data_full) begin
                    wr_ack[lock_port_q] = 1'b1;
                    l2_wr_data_push     = 1'b1;
                    l2_wr_data          = wr_data[lock_port_q];
                    l2_wr_data_be       = wr_be[lock_port_q];
                    beats_left_d        = beats_left_q - 1'b1;
                    if (beats_left_q == SIZE_W'(1)) begin
                        state_d = StArb;
                    end
                end
            end
            default: state_d = StArb;
        endcase
    end

    // Grant credit and return debit may land on the same port in the same cycle.
    always_comb begin
        logic [31:0] add;
        logic [31:0] sum;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            ret_hit[i] = l2_rd_data_valid & (32'(l2_rd_sub_id) == i);
            add = '0;
            if (grant && sel_onehot[i] && (req_rnw[i] || req_is_amo[i])) begin
                add = req_is_amo[i] ? 32'd1 : 32'(req_size[i]) + 32'd1;
            end
            sum = 32'(rd_cnt_q[i]) + add;
            if (ret_hit[i] && sum != '0) begin
                sum = sum - 32'd1;
            end
            rd_cnt_d[i] = CNT_W'(sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StArb;
            beats_left_q <= '0;
            lock_port_q  <= '0;
            rd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            lock_port_q  <= lock_port_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign l2_addr        = l2_req.addr[ADDR_W-1:0];
    assign l2_rnw         = l2_req.rnw;
    assign l2_is_amo      = l2_req.is_amo;
    assign l2_size        = l2_req.size[SIZE_W-1:0];
    assign l2_sub_id      = l2_req.sub_id[SUB_W-1:0];
    assign unused_l2_req  = ^l2_req;

    assign l2_rd_data_ack = l2_rd_data_valid;
    assign resp_valid     = ret_hit & {NUM_PORTS{~rst}};
    assign resp_data      = rst ? '0 : l2_rd_data;

endmodule

// File: doc/l1_burst_arbiter.md
# l1_burst_arbiter

N-port arbiter between the L1 requesters (dcache, icache, MMU walkers, etc.) and the L2 requester interface. It is the parametrised successor to the fixed-priority L1 arbiter and adds four things: a configurable port count, multi-beat write bursts with a data-phase lock, per-port read-beat credit limiting, and an optional round-robin grant policy. Read-return data is routed back to the issuing port by sub-id.

## Interface
Parameters:
- NUM_PORTS, 4, number of L1 requesters; port 0 has highest fixed priority.
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- SIZE_W, 5, burst-size field width; beats = size+1.
- MAX_RD_BEATS, 16, outstanding read beats allowed per port.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  [NUM_PORTS]  request pending.
- req_addr  in  [NUM_PORTS][ADDR_W]  word address.
- req_rnw, req_is_amo  in  [NUM_PORTS]  read-not-write; AMO flag.
- req_size  in  [NUM_PORTS][SIZE_W]  burst size, or AMO type.
- req_ack  out  [NUM_PORTS]  request accepted this cycle.
- wr_data, wr_be  in  [NUM_PORTS][DATA_W], [NUM_PORTS][DATA_W/8]  write beat and byte enables.
- wr_valid  in  [NUM_PORTS]  write beat available.
- wr_ack  out  [NUM_PORTS]  write beat consumed.
- l2_request_full, l2_data_full  in  1  L2 FIFO status.
- l2_request_push  out  1  push address FIFO.
- l2_addr, l2_rnw, l2_is_amo, l2_size, l2_sub_id  out  ADDR_W/1/1/SIZE_W/clog2(NUM_PORTS)  pushed request fields.
- l2_wr_data_push  out  1  push data FIFO.
- l2_wr_data, l2_wr_data_be  out  DATA_W, DATA_W/8  pushed write beat.
- l2_rd_data_valid  in  1  read-return beat.
- l2_rd_data  in  DATA_W  read-return data.
- l2_rd_sub_id  in  clog2(NUM_PORTS)  return destination.
- l2_rd_data_ack  out  1  always equal to l2_rd_data_valid.
- resp_data  out  DATA_W  broadcast return data.
- resp_valid  out  [NUM_PORTS]  return beat for this port.

## Operation
- States: ARB and WDATA.
- push_ready = ~(l2_request_full | l2_data_full).
- Eligibility: port i is eligible when req_valid[i] is set and one of the following holds:
  - it is a write and wr_valid[i] is set;
  - it is a read and rd_cnt[i] + size + 1 <= MAX_RD_BEATS;
  - it is an AMO; an AMO counts as 1 read beat.
- ARB state:
  - Grant the selected eligible port when push_ready is high.
  - On a grant, l2_request_push=1 and req_ack[g]=1.
  - A write grant also pushes its first beat: l2_wr_data_push=1, wr_ack[g]=1.
  - A write grant with size>0 moves to WDATA with beats_left=size and lock_port=g.
- WDATA state:
  - No address grants.
  - Each cycle with wr_valid[lock_port] and ~l2_data_full: push one beat, assert wr_ack, decrement beats_left.
  - Return to ARB on the cycle the last beat is pushed.
- Read credits:
  - rd_cnt[i] += size+1 on read or AMO grant (AMO adds 1).
  - rd_cnt[i] -= 1 per return beat with l2_rd_sub_id==i.
  - A grant and a return on the same cycle apply both updates.
  - Counter width is clog2(MAX_RD_BEATS+1) and must never wrap.
- Returns: resp_valid[i] = l2_rd_data_valid & (l2_rd_sub_id==i). A sub_id >= NUM_PORTS is acked and dropped.
- l2_sub_id is the granted port index.

## Timing
- Grant, ack and push are combinational: a request presented in cycle N is pushed in cycle N when eligible.
- Registered state (state, beats_left, lock_port, rd_cnt, rr_ptr) updates on the clk edge following the event.
- Return routing has zero latency.
- Reset values:
  - state=ARB; all counters and rr_ptr are 0.
  - All push, ack and resp_valid outputs are 0.
  - Data and address outputs are don't-care, driven 0.
- Reset mid-burst abandons the remaining beats; the L2 side must be reset together with this block.
- While l2_data_full is high in WDATA, beats stall with no loss.

## Configuration
- L1_ARB_ROUND_ROBIN_EN defined:
  - Selection is round-robin starting at rr_ptr.
  - After each grant, rr_ptr = g+1, wrapping from NUM_PORTS-1 to 0.
- L1_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest-index eligible port wins.
  - rr_ptr is not implemented.

## Structure
- A shared package holds:
  - the l2 request struct (addr, rnw, is_amo, size, sub_id);
  - the arbiter state enum;
  - L1 port-ID constants.
- One sub-module, rr_priority_select (vector plus start pointer in, one-hot and encoded out).
  - It is used with ptr tied to 0 when round-robin is compiled out.

## Test plan
- Single-beat write, port 1, l2 not full: push, req_ack[1], wr_ack[1] all in the same cycle; l2_sub_id=1; state stays ARB.
- Write burst size=3 on port 0, with port 2 requesting a read:
  - exactly 4 data beats are pushed;
  - a 2-cycle l2_data_full stall inside the burst holds the beats;
  - port 2 is granted only after the last beat.
- Credit limit, MAX_RD_BEATS=16:
  - port 3 issues a size=15 read; rd_cnt=16 and a further read is blocked;
  - one return beat brings rd_cnt to 15, which still blocks (15+1+1 > 16);
  - a size=0 read is granted once rd_cnt=15; after that grant rd_cnt=16 again.
- Round-robin on (MACRO defined), all 4 ports requesting reads continuously: grants follow 0,1,2,3,0. With the MACRO undefined, port 0 wins every grant.
- Same-cycle size=1 read grant and return beat on port 2: rd_cnt goes from 5 to 6.
- Async reset asserted mid-burst with beats_left=2: outputs go to 0 immediately; after release, state=ARB and all rd_cnt=0.
